// File: rtl/traffic_sensor_cond.sv
// Sync + debounce lane detectors and time green phases into inp_a/inp_b holds; `TSC_STATS_EN adds arrival counters.
// Latency: raw detector edge to veh_x is 2+DEB_CYC cycles; inp_x is combinational from lane state and light codes.
// No backpressure: free-running, one decision per cycle, no handshake.
module traffic_sensor_cond #(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned MIN_GREEN = 16,
    parameter int unsigned MAX_EXT   = 64,
    parameter int unsigned CW        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sense_a_raw,
    input  logic        sense_b_raw,
    input  logic [1:0]  l_a,
    input  logic [1:0]  l_b,
    output logic        inp_a,
    output logic        inp_b,
    output logic        veh_a,
    output logic        veh_b,
    output logic        conflict,
    output logic [15:0] cnt_a,
    output logic [15:0] cnt_b
);
    typedef enum logic [1:0] {ST_OFF, ST_MIN, ST_EXT, ST_REL} lane_st_e;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] MIN_LOAD = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] EXT_LOAD = CW'(MAX_EXT - 1);

    logic [1:0]         raw, sync1_q, sync2_q, veh_q, veh_d, green, veh_oth, hold;
    logic [1:0][CW-1:0] deb_q, deb_d;
    logic               both_green, conflict_q, conflict_d;

    // Bit 0 is lane A, bit 1 is lane B throughout.
    assign raw        = {sense_b_raw, sense_a_raw};
    assign green      = {l_b == 2'd0, l_a == 2'd0};
    assign veh_oth    = {veh_q[0], veh_q[1]};
    assign both_green = &green;
    assign conflict_d = conflict_q | both_green;

    always_comb begin
        veh_d = veh_q;
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == veh_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DEB_LAST) begin
                veh_d[i] = ~veh_q[i];
                deb_d[i] = '0;
            end else begin
                deb_d[i] = deb_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            veh_q      <= '0;
            deb_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            veh_q      <= veh_d;
            deb_q      <= deb_d;
            conflict_q <= conflict_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        lane_st_e      st_q, st_d;
        logic [CW-1:0] tmr_q, tmr_d;
        logic          ext_hold, hold_c;

        assign ext_hold = veh_q[g] | ~veh_oth[g];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st_q  <= ST_OFF;
                tmr_q <= '0;
            end else begin
                st_q  <= st_d;
                tmr_q <= tmr_d;
            end
        end

        // Leaving green always wins, so a phase can never resume mid-way.
        always_comb begin
            st_d  = st_q;
            tmr_d = tmr_q;
            if (!green[g]) begin
                st_d  = ST_OFF;
                tmr_d = '0;
            end else begin
                case (st_q)
                    ST_OFF: begin
                        st_d  = ST_MIN;
                        tmr_d = MIN_LOAD;
                    end
                    ST_MIN: begin
                        if (tmr_q == '0) begin
                            st_d  = ST_EXT;
                            tmr_d = EXT_LOAD;
                        end else begin
                            tmr_d = tmr_q - CW'(1);
                        end
                    end
                    ST_EXT: begin
                        if ((tmr_q == '0 && veh_oth[g]) || !ext_hold) begin
                            st_d = ST_REL;
                        end else if (veh_oth[g]) begin
                            tmr_d = tmr_q - CW'(1);
                        end
                    end
                    default: st_d = ST_REL;
                endcase
            end
        end

        always_comb begin
            case (st_q)
                ST_OFF:  hold_c = green[g];
                ST_MIN:  hold_c = 1'b1;
                ST_EXT:  hold_c = ext_hold;
                default: hold_c = 1'b0;
            endcase
        end

        assign hold[g] = hold_c;
    end

    // Dropping both holds pushes the controller out of an illegal double green.
    assign inp_a    = hold[0] & ~(conflict_q | both_green);
    assign inp_b    = hold[1] & ~(conflict_q | both_green);
    assign veh_a    = veh_q[0];
    assign veh_b    = veh_q[1];
    assign conflict = conflict_q;

`ifdef TSC_STATS_EN
    logic [1:0]        veh_dly_q;
    logic [1:0][15:0]  cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            veh_dly_q <= '0;
            cnt_q     <= '0;
        end else begin
            veh_dly_q <= veh_q;
            for (int i = 0; i < 2; i++) begin
                if (veh_q[i] && !veh_dly_q[i] && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign cnt_a = cnt_q[0];
    assign cnt_b = cnt_q[1];
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Directed bench for traffic_sensor_cond: per-cycle expectations are queued when inputs are driven and checked at the falling edge.
module tb_traffic_sensor_cond;
    localparam int S_INP_A = 0;
    localparam int S_INP_B = 1;
    localparam int S_VEH_A = 2;
    localparam int S_VEH_B = 3;
    localparam int S_CONF  = 4;
    localparam int S_CNT_A = 5;
    localparam int S_CNT_B = 6;

    logic        clk;
    logic        reset;
    logic        sense_a_raw, sense_b_raw;
    logic [1:0]  l_a, l_b;
    logic        inp_a, inp_b, veh_a, veh_b, conflict;
    logic [15:0] cnt_a, cnt_b;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   chk_cnt = 0;
    int   err_cnt = 0;

    traffic_sensor_cond #(
        .DEB_CYC   (3),
        .MIN_GREEN (4),
        .MAX_EXT   (8),
        .CW        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sense_a_raw (sense_a_raw),
        .sense_b_raw (sense_b_raw),
        .l_a         (l_a),
        .l_b         (l_b),
        .inp_a       (inp_a),
        .inp_b       (inp_b),
        .veh_a       (veh_a),
        .veh_b       (veh_b),
        .conflict    (conflict),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sig_val(input int sel);
        case (sel)
            S_INP_A: return {15'd0, inp_a};
            S_INP_B: return {15'd0, inp_b};
            S_VEH_A: return {15'd0, veh_a};
            S_VEH_B: return {15'd0, veh_b};
            S_CONF:  return {15'd0, conflict};
            S_CNT_A: return cnt_a;
            default: return cnt_b;
        endcase
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef TSC_STATS_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic expect_sig(input string tag, input int sel, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, sig_val(e.sel), e.val);
        end
    endtask

    // Inputs are driven 1ns after a rising edge; outputs checked on the falling edge.
    task automatic tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", err_cnt, chk_cnt);
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        sense_a_raw = 1'b0;
        sense_b_raw = 1'b0;
        l_a         = 2'd2;
        l_b         = 2'd2;
        @(posedge clk);
        #1;
        expect_sig("rst_inp_a", S_INP_A, 16'd0);
        expect_sig("rst_inp_b", S_INP_B, 16'd0);
        expect_sig("rst_veh_a", S_VEH_A, 16'd0);
        expect_sig("rst_veh_b", S_VEH_B, 16'd0);
        expect_sig("rst_conf",  S_CONF,  16'd0);
        expect_sig("rst_cnt_a", S_CNT_A, 16'd0);
        expect_sig("rst_cnt_b", S_CNT_B, 16'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();

        // Debounce: two-sample glitch ignored, then rise and fall each take 2+3 cycles.
        sense_a_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) sense_a_raw = 1'b0;
            expect_sig("deb_glitch", S_VEH_A, 16'd0);
            tick();
        end
        sense_a_raw = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            expect_sig("deb_rise", S_VEH_A, 16'(k >= 5));
            tick();
        end
        sense_a_raw = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            expect_sig("deb_fall", S_VEH_A, 16'(k < 5));
            tick();
        end

        // Minimum green then resting extension with no demand anywhere.
        l_a = 2'd0;
        for (int k = 0; k < 30; k++) begin
            expect_sig("min_hold_a", S_INP_A, 16'd1);
            expect_sig("min_idle_b", S_INP_B, 16'd0);
            tick();
        end
        l_a = 2'd2;
        tick();
        expect_sig("min_off_a", S_INP_A, 16'd0);
        tick();

        // Extension cap with demand on both lanes: 1 OFF + 4 MIN + 8 EXT cycles.
        sense_a_raw = 1'b1;
        sense_b_raw = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        expect_sig("cap_veh_a", S_VEH_A, 16'd1);
        expect_sig("cap_veh_b", S_VEH_B, 16'd1);
        tick();
        l_a = 2'd0;
        for (int k = 0; k < 18; k++) begin
            expect_sig("cap_hold_a", S_INP_A, 16'(k <= 12));
            tick();
        end
        l_a = 2'd2;
        tick();
        tick();

        // Gap-out: veh_a drops during extension, later returns while still green.
        l_a = 2'd0;
        expect_sig("gap_start", S_INP_A, 16'd1);
        tick();
        sense_a_raw = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 7) sense_a_raw = 1'b1;
            expect_sig("gap_hold_a", S_INP_A, 16'(k <= 5));
            expect_sig("gap_veh_a",  S_VEH_A, 16'((k < 6) || (k >= 12)));
            tick();
        end
        l_a = 2'd2;
        tick();
        expect_sig("gap_off_a", S_INP_A, 16'd0);
        tick();
        l_a = 2'd0;
        for (int k = 0; k < 5; k++) begin
            expect_sig("gap_reentry_a", S_INP_A, 16'd1);
            tick();
        end
        l_a = 2'd2;
        tick();
        tick();

        // Conflict: simultaneous green blanks holds, sticky until async reset.
        sense_a_raw = 1'b0;
        sense_b_raw = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        l_a = 2'd0;
        l_b = 2'd0;
        expect_sig("conf_same_a", S_INP_A, 16'd0);
        expect_sig("conf_same_b", S_INP_B, 16'd0);
        expect_sig("conf_not_yet", S_CONF, 16'd0);
        tick();
        l_b = 2'd2;
        for (int k = 0; k < 3; k++) begin
            expect_sig("conf_sticky", S_CONF, 16'd1);
            expect_sig("conf_gate_a", S_INP_A, 16'd0);
            expect_sig("conf_gate_b", S_INP_B, 16'd0);
            tick();
        end
        reset = 1'b0;
        #1;
        expect_sig("conf_async_clr", S_CONF, 16'd0);
        drain();
        #1;
        reset = 1'b1;
        l_a   = 2'd2;
        expect_sig("conf_after_rst", S_CONF, 16'd0);
        tick();
        tick();

        // Arrivals on lane B, then async reset while lane A is in its minimum green.
        for (int p = 0; p < 3; p++) begin
            sense_b_raw = 1'b1;
            for (int k = 0; k < 7; k++) begin
                if (k == 5) begin
                    expect_sig("stat_veh_b", S_VEH_B, 16'd1);
                    expect_sig("stat_cnt_pre", S_CNT_B, exp_cnt(p));
                end
                if (k == 6) expect_sig("stat_cnt_post", S_CNT_B, exp_cnt(p + 1));
                tick();
            end
            sense_b_raw = 1'b0;
            for (int k = 0; k < 7; k++) tick();
            expect_sig("stat_cnt_b", S_CNT_B, exp_cnt(p + 1));
            expect_sig("stat_cnt_a", S_CNT_A, 16'd0);
            tick();
        end
        l_a = 2'd0;
        expect_sig("mid_off_a", S_INP_A, 16'd1);
        tick();
        expect_sig("mid_min_a", S_INP_A, 16'd1);
        tick();
        reset = 1'b0;
        #1;
        expect_sig("mid_rst_cnt_b", S_CNT_B, 16'd0);
        expect_sig("mid_rst_veh_b", S_VEH_B, 16'd0);
        drain();
        l_a = 2'd1;
        #1;
        expect_sig("mid_rst_lane_off", S_INP_A, 16'd0);
        drain();
        reset = 1'b1;
        l_a   = 2'd2;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
